// File: rtl/nmr_acq_echo_sequencer.sv
// CPMG echo-train acquisition scheduler: after START and an initial delay it emits
// ECHO_NUM windows on ACQ_WND/ACQ_EN. Optional ABORT input under `NMR_SEQ_ABORT_EN`.
module nmr_acq_echo_sequencer #(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned ECHO_WIDTH = 16
) (
  input  logic                  ADC_CLK,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic [CNT_WIDTH-1:0]  INIT_DLY,
  input  logic [CNT_WIDTH-1:0]  ECHO_PERIOD,
  input  logic [CNT_WIDTH-1:0]  ACQ_LEN,
  input  logic [ECHO_WIDTH-1:0] ECHO_NUM,
  output logic                  ACQ_WND,
  output logic                  ACQ_EN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [ECHO_WIDTH-1:0] ECHO_CNT
`ifdef NMR_SEQ_ABORT_EN
  ,
  input  logic                  ABORT
`endif
);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    INIT = 5'b00010,
    WND  = 5'b00100,
    GAP  = 5'b01000,
    FIN  = 5'b10000
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  period_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [ECHO_WIDTH-1:0] num_q;

  logic [CNT_WIDTH-1:0]  lw_c;
  logic [CNT_WIDTH-1:0]  gap_c;
  logic                  last_c;

  // Window length floored at 1; gap length is the clamped remainder of the period.
  always_comb begin
    lw_c   = (len_q == '0) ? CNT_WIDTH'(1) : len_q;
    gap_c  = (period_q > lw_c) ? (period_q - lw_c) : CNT_WIDTH'(1);
    last_c = ((ECHO_CNT + ECHO_WIDTH'(1)) == num_q);
  end

  always_ff @(posedge ADC_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      cnt      <= '0;
      period_q <= '0;
      len_q    <= '0;
      num_q    <= '0;
      ACQ_WND  <= 1'b0;
      ACQ_EN   <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ECHO_CNT <= '0;
    end
`ifdef NMR_SEQ_ABORT_EN
    else if (ABORT && (state != IDLE)) begin
      state   <= IDLE;
      cnt     <= '0;
      ACQ_WND <= 1'b0;
      ACQ_EN  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b1;
    end
`endif
    else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            // The init delay goes straight into the counter; the rest is shadowed.
            cnt      <= INIT_DLY;
            period_q <= ECHO_PERIOD;
            len_q    <= ACQ_LEN;
            num_q    <= ECHO_NUM;
            ECHO_CNT <= '0;
            BUSY     <= 1'b1;
            state    <= INIT;
          end
        end

        INIT: begin
          if (cnt == '0) begin
            if (num_q == '0) begin
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              state <= FIN;
            end else begin
              ACQ_WND <= 1'b1;
              ACQ_EN  <= 1'b1;
              cnt     <= lw_c - CNT_WIDTH'(1);
              state   <= WND;
            end
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end

        WND: begin
          if (cnt == '0) begin
            ACQ_WND  <= 1'b0;
            ACQ_EN   <= 1'b0;
            ECHO_CNT <= ECHO_CNT + ECHO_WIDTH'(1);
            if (last_c) begin
              state <= FIN;
            end else begin
              cnt   <= gap_c - CNT_WIDTH'(1);
              state <= GAP;
            end
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end

        GAP: begin
          if (cnt == '0) begin
            ACQ_WND <= 1'b1;
            ACQ_EN  <= 1'b1;
            cnt     <= lw_c - CNT_WIDTH'(1);
            state   <= WND;
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end

        FIN: begin
          // After a window train FIN first idles one cycle, then pulses DONE.
          if (!DONE) begin
            DONE <= 1'b1;
            BUSY <= 1'b0;
          end else begin
            DONE  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          ACQ_WND <= 1'b0;
          ACQ_EN  <= 1'b0;
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
          cnt     <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nmr_acq_echo_sequencer.sv
// Self-checking bench for nmr_acq_echo_sequencer against a closed-form timing model.
// Abort scenario compiled only with NMR_SEQ_ABORT_EN.
module tb_nmr_acq_echo_sequencer;

  typedef struct packed {
    logic        wnd;
    logic        en;
    logic        busy;
    logic        done;
    logic [15:0] ecnt;
  } obs_t;

  logic        ADC_CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [31:0] INIT_DLY;
  logic [31:0] ECHO_PERIOD;
  logic [31:0] ACQ_LEN;
  logic [15:0] ECHO_NUM;
  logic        ACQ_WND;
  logic        ACQ_EN;
  logic        BUSY;
  logic        DONE;
  logic [15:0] ECHO_CNT;
`ifdef NMR_SEQ_ABORT_EN
  logic        ABORT;
`endif

  int checks = 0;
  int errors = 0;

  obs_t got;
  obs_t exp_o;
  assign got = {ACQ_WND, ACQ_EN, BUSY, DONE, ECHO_CNT};

  nmr_acq_echo_sequencer #(.CNT_WIDTH(32), .ECHO_WIDTH(16)) dut (
    .ADC_CLK     (ADC_CLK),
    .RESET_N     (RESET_N),
    .START       (START),
    .INIT_DLY    (INIT_DLY),
    .ECHO_PERIOD (ECHO_PERIOD),
    .ACQ_LEN     (ACQ_LEN),
    .ECHO_NUM    (ECHO_NUM),
    .ACQ_WND     (ACQ_WND),
    .ACQ_EN      (ACQ_EN),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ECHO_CNT    (ECHO_CNT)
`ifdef NMR_SEQ_ABORT_EN
    ,
    .ABORT       (ABORT)
`endif
  );

  always #5 ADC_CLK = ~ADC_CLK;

  // Edge (relative to the START-sampling edge) that carries the DONE pulse.
  function automatic longint done_at(longint d, longint p, longint l, longint n);
    longint lw, pe;
    lw = (l == 0) ? 1 : l;
    pe = (p > lw) ? p : lw + 1;
    return (n == 0) ? d + 1 : (d + 1) + (n - 1) * pe + lw + 1;
  endfunction

  // Expected outputs just after relative edge k of a train accepted at edge 0.
  function automatic obs_t model(longint d, longint p, longint l, longint n, longint k);
    obs_t o;
    longint lw, pe, r0, i, c;
    o  = '0;
    lw = (l == 0) ? 1 : l;
    pe = (p > lw) ? p : lw + 1;
    r0 = d + 1;
    o.busy = (k < done_at(d, p, l, n));
    o.done = (k == done_at(d, p, l, n));
    if (n > 0 && k >= r0) begin
      i = (k - r0) / pe;
      if (i < n && ((k - r0) % pe) < lw) begin
        o.wnd = 1'b1;
        o.en  = 1'b1;
      end
    end
    if (n > 0 && k >= r0 + lw) begin
      c = (k - r0 - lw) / pe + 1;
      o.ecnt = 16'((c > n) ? n : c);
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge ADC_CLK);
    #1;
  endtask

  task automatic set_params(int unsigned d, int unsigned p, int unsigned l, int unsigned n);
    INIT_DLY    = 32'(d);
    ECHO_PERIOD = 32'(p);
    ACQ_LEN     = 32'(l);
    ECHO_NUM    = 16'(n);
  endtask

  task automatic scramble_params();
    set_params($urandom_range(40, 0), $urandom_range(40, 0), $urandom_range(40, 0),
               $urandom_range(9, 0));
  endtask

  // Pulse START for one edge; returns just after the accepting edge.
  task automatic start_train(int unsigned d, int unsigned p, int unsigned l, int unsigned n);
    set_params(d, p, l, n);
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (got !== obs_t'('0)) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", got, obs_t'('0));
    end
  endtask

  task automatic test_echo_train();
    int unsigned d, p, l, n;
    longint dk;
    for (int t = 0; t < 7; t++) begin
      if (t == 0) begin
        d = 10; p = 20; l = 5; n = 3;
      end else begin
        d = $urandom_range(15, 0); p = $urandom_range(25, 0);
        l = $urandom_range(10, 0); n = $urandom_range(5, 1);
      end
      dk = done_at(d, p, l, n);
      start_train(d, p, l, n);
      for (longint k = 0; k <= dk + 1; k++) begin
        exp_o = model(d, p, l, n, k);
        checks++;
        if (got !== exp_o) begin
          errors++;
          $display("FAIL echo_train t=%0d k=%0d got=%h exp=%h", t, k, got, exp_o);
        end
        scramble_params();
        tick();
      end
    end
  endtask

  task automatic test_zero_echo();
    int unsigned d;
    for (int t = 0; t < 3; t++) begin
      d = (t == 0) ? 4 : $urandom_range(12, 0);
      start_train(d, $urandom_range(20, 0), $urandom_range(8, 0), 0);
      for (longint k = 0; k <= longint'(d) + 3; k++) begin
        exp_o = model(d, 0, 0, 0, k);
        checks++;
        if (got !== exp_o) begin
          errors++;
          $display("FAIL zero_echo d=%0d k=%0d got=%h exp=%h", d, k, got, exp_o);
        end
        tick();
      end
    end
  endtask

  task automatic test_clamp();
    int unsigned d, p, l, n;
    longint dk;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0:       begin d = 2; p = 3; l = 8; n = 2; end
        1:       begin d = 1; p = $urandom_range(6, 0); l = 0; n = 3; end
        default: begin d = 0; p = 7; l = 7; n = 3; end
      endcase
      dk = done_at(d, p, l, n);
      start_train(d, p, l, n);
      for (longint k = 0; k <= dk + 1; k++) begin
        exp_o = model(d, p, l, n, k);
        checks++;
        if (got !== exp_o) begin
          errors++;
          $display("FAIL clamp t=%0d k=%0d got=%h exp=%h", t, k, got, exp_o);
        end
        tick();
      end
    end
  endtask

  task automatic test_busy_restart();
    longint dk;
    dk = done_at(10, 20, 5, 3);
    start_train(10, 20, 5, 3);
    for (longint k = 0; k <= dk + 1; k++) begin
      exp_o = model(10, 20, 5, 3, k);
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL busy_restart k=%0d got=%h exp=%h", k, got, exp_o);
      end
      START = (k == 32) || (k == 8);
      if (START) set_params(1, 4, 2, 7);
      tick();
    end
    START = 1'b0;
  endtask

  task automatic test_back_to_back();
    int unsigned da, pa, la, na, db, pb, lb, nb;
    longint dka, dkb;
    for (int t = 0; t < 3; t++) begin
      da = $urandom_range(8, 0); pa = $urandom_range(12, 0);
      la = $urandom_range(6, 0); na = $urandom_range(3, 0);
      db = $urandom_range(8, 0); pb = $urandom_range(12, 0);
      lb = $urandom_range(6, 0); nb = $urandom_range(3, 1);
      dka = done_at(da, pa, la, na);
      dkb = done_at(db, pb, lb, nb);
      start_train(da, pa, la, na);
      // START held across the DONE cycle: ignored there, accepted one edge later.
      for (longint k = 0; k <= dka + 1; k++) begin
        exp_o = model(da, pa, la, na, k);
        checks++;
        if (got !== exp_o) begin
          errors++;
          $display("FAIL b2b_first t=%0d k=%0d got=%h exp=%h", t, k, got, exp_o);
        end
        if (k == dka) begin
          set_params(db, pb, lb, nb);
          START = 1'b1;
        end
        tick();
      end
      START = 1'b0;
      for (longint k = 0; k <= dkb + 1; k++) begin
        exp_o = model(db, pb, lb, nb, k);
        checks++;
        if (got !== exp_o) begin
          errors++;
          $display("FAIL b2b_second t=%0d k=%0d got=%h exp=%h", t, k, got, exp_o);
        end
        tick();
      end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned d, p, l, n;
    longint dk;
    start_train(10, 20, 5, 3);
    for (longint k = 0; k < 13; k++) tick();
    #3;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (got !== obs_t'('0)) begin
      errors++;
      $display("FAIL reset_mid_async got=%h exp=%h", got, obs_t'('0));
    end
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    checks++;
    if (got !== obs_t'('0)) begin
      errors++;
      $display("FAIL reset_mid_release got=%h exp=%h", got, obs_t'('0));
    end
    d = $urandom_range(6, 0); p = $urandom_range(10, 0);
    l = $urandom_range(5, 0); n = $urandom_range(4, 1);
    dk = done_at(d, p, l, n);
    start_train(d, p, l, n);
    for (longint k = 0; k <= dk + 1; k++) begin
      exp_o = model(d, p, l, n, k);
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL reset_mid_fresh k=%0d got=%h exp=%h", k, got, exp_o);
      end
      tick();
    end
  endtask

`ifdef NMR_SEQ_ABORT_EN
  task automatic test_abort();
    start_train(10, 20, 5, 3);
    for (longint k = 0; k <= 32; k++) begin
      exp_o = model(10, 20, 5, 3, k);
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL abort_pre k=%0d got=%h exp=%h", k, got, exp_o);
      end
      if (k < 32) tick();
    end
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    exp_o = '{wnd: 1'b0, en: 1'b0, busy: 1'b0, done: 1'b1, ecnt: 16'd1};
    checks++;
    if (got !== exp_o) begin
      errors++;
      $display("FAIL abort_edge got=%h exp=%h", got, exp_o);
    end
    tick();
    exp_o.done = 1'b0;
    checks++;
    if (got !== exp_o) begin
      errors++;
      $display("FAIL abort_after got=%h exp=%h", got, exp_o);
    end
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    checks++;
    if (got !== exp_o) begin
      errors++;
      $display("FAIL abort_idle got=%h exp=%h", got, exp_o);
    end
  endtask
`endif

  initial begin
    RESET_N = 1'b0;
    START   = 1'b0;
    set_params(0, 0, 0, 0);
`ifdef NMR_SEQ_ABORT_EN
    ABORT   = 1'b0;
`endif
    tick();
    tick();
    test_reset();
    RESET_N = 1'b1;
    tick();
    test_reset();
    test_echo_train();
    test_zero_echo();
    test_clamp();
    test_busy_restart();
    test_back_to_back();
    test_reset_mid();
`ifdef NMR_SEQ_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nmr_acq_echo_sequencer.md
Name: nmr_acq_echo_sequencer

Overview:
Multi-echo acquisition scheduler that drives the ACQ_WND / ACQ_EN control pair of the RX/duplexer enable window generator for a CPMG-style echo train. On a START pulse it waits an initial delay, then generates ECHO_NUM acquisition windows. Each window is ACQ_LEN cycles long, and window rising edges are ECHO_PERIOD cycles apart. It reports progress (BUSY, ECHO_CNT) and completion (DONE) to the pulse-program control logic. It runs in the ADC_CLK domain alongside the window generator and ADC capture.

Parameters:
CNT_WIDTH, 32, width of the INIT_DLY, ECHO_PERIOD and ACQ_LEN counters and inputs
ECHO_WIDTH, 16, width of ECHO_NUM and ECHO_CNT

Ports:
ADC_CLK  in  1  system clock; all logic is synchronous to its rising edge
RESET_N  in  1  asynchronous, active-low reset
START  in  1  single-cycle start request, sampled only in IDLE
INIT_DLY  in  CNT_WIDTH  cycles from START sample to the first window
ECHO_PERIOD  in  CNT_WIDTH  cycles between consecutive window rising edges
ACQ_LEN  in  CNT_WIDTH  window length in cycles
ECHO_NUM  in  ECHO_WIDTH  number of windows to generate
ACQ_WND  out  1  acquisition window request to the window generator
ACQ_EN  out  1  acquisition enable; frames each window
BUSY  out  1  high from START acceptance until DONE
DONE  out  1  one-cycle completion pulse
ECHO_CNT  out  ECHO_WIDTH  number of windows completed in the current train
ABORT  in  1  present only with NMR_SEQ_ABORT_EN (see Optional Feature)

Behaviour:
- Reset (RESET_N low, asynchronous): state IDLE. ACQ_WND, ACQ_EN, BUSY and DONE = 0. ECHO_CNT = 0. All counters = 0.
- Registered outputs. One-hot state machine: IDLE, INIT, WND, GAP, FIN.
- IDLE:
  - START=1 latches INIT_DLY, ECHO_PERIOD, ACQ_LEN and ECHO_NUM into shadow registers, clears ECHO_CNT, sets BUSY=1 and goes to INIT.
  - Input changes after acceptance have no effect until the next START.
- INIT: counts the latched INIT_DLY.
  - ACQ_WND and ACQ_EN rise on clock edge INIT_DLY+1 after the edge that sampled START. INIT_DLY=0 gives a rise on the next edge.
  - If the latched ECHO_NUM=0: go to FIN instead. No window is generated.
- WND: ACQ_WND = ACQ_EN = 1 for exactly Lw cycles, where Lw = max(ACQ_LEN, 1).
  - On exit, ECHO_CNT increments on the same edge that lowers ACQ_WND and ACQ_EN.
  - If ECHO_CNT+1 = ECHO_NUM: go to FIN. Otherwise go to GAP.
- GAP: outputs low for G = max(ECHO_PERIOD - Lw, 1) cycles, then go to WND.
  - Rising-edge spacing is therefore max(ECHO_PERIOD, Lw+1).
  - The subtraction is unsigned at CNT_WIDTH bits and is clamped, never wrapped.
- FIN: DONE=1 for one cycle and BUSY=0 on the same edge, then IDLE.
  - DONE is asserted one cycle after the final ACQ_WND fall.
  - With ECHO_NUM=0, DONE is asserted on edge INIT_DLY+1.
- START while BUSY=1 is ignored: no restart and no parameter reload.
- START in the same cycle as FIN is ignored; it is accepted again from IDLE one cycle later.
- ECHO_CNT holds its final value after DONE until the next accepted START.
- Timing constraint on the downstream window generator: it re-arms through its S4->S0 path, so G >= 2 is required when downstream RX_DELAY > 0. This block does not enforce it.

Optional Feature:
NMR_SEQ_ABORT_EN
- Defined:
  - Adds the ABORT input. ABORT=1, sampled in any non-IDLE state, forces IDLE on the next edge.
  - On that edge: ACQ_WND=0, ACQ_EN=0, BUSY=0, and DONE=1 for one cycle. ECHO_CNT holds the count of windows completed so far; a window cut short by ABORT is not counted.
  - ABORT takes priority over all other transitions. ABORT in IDLE has no effect.
- Undefined: the ABORT port is absent; a train ends only on completion or on RESET_N.

Test Plan:
1. INIT_DLY=10, ACQ_LEN=5, ECHO_PERIOD=20, ECHO_NUM=3, START pulse -> ACQ_WND rises at START+11, +31 and +51, each high for 5 cycles. ECHO_CNT steps 1, 2, 3. DONE pulses at +57, with BUSY falling on the same edge.
2. ECHO_NUM=0, INIT_DLY=4 -> no ACQ_WND. DONE at START+5. ECHO_CNT=0.
3. ACQ_LEN=8, ECHO_PERIOD=3, ECHO_NUM=2; then ACQ_LEN=0 -> first case: rises 9 cycles apart (gap clamped to 1). ACQ_LEN=0 case: 1-cycle windows.
4. Second START during window 2 of test 1 -> ignored; the timing of test 1 is unchanged.
5. RESET_N low mid-WND -> ACQ_WND, ACQ_EN, BUSY and ECHO_CNT go to 0 asynchronously. The next START after release gives a fresh train.
6. (NMR_SEQ_ABORT_EN) ABORT during window 2 of test 1 -> outputs low on the next edge, DONE pulse, ECHO_CNT=1.
